// File: rtl/scoreboard_pkg.sv
// Shared widths, default unit latencies and unit encodings for the
// multi-port register scoreboard.
package scoreboard_pkg;

   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 4;
   localparam int NUNIT_DEF = 4;
   localparam int DEPTH_DEF = 5;

   // Entry field widths for the default configuration.
   localparam int PENDING_W = 1;
   localparam int LAT_W     = 3;
   localparam int UNIT_W    = 2;
   localparam int ROW_W     = DEPTH_DEF;

   localparam logic [1:0] UNIT0 = 2'd0;
   localparam logic [1:0] UNIT1 = 2'd1;
   localparam logic [1:0] UNIT2 = 2'd2;
   localparam logic [1:0] UNIT3 = 2'd3;

   // Packed NUNIT x 3 bits, unit0 in the low slice.
   localparam logic [NUNIT_DEF*LAT_W-1:0] UNIT_LAT_DEF = {3'd1, 3'd2, 3'd3, 3'd5};

   function automatic int unit_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard entry: pending flag, producing unit and a latency row
// that shifts toward expiry, with write and flush applied after the shift.
module scoreboard_entry
   import scoreboard_pkg::*;
#(
   parameter int UW    = UNIT_W,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [UW-1:0]    wr_unit,
   input  logic [DEPTH-1:0] wr_row,
   output logic             pending,
   output logic [UW-1:0]    unit,
   output logic [DEPTH-1:0] row,
   output logic             pending_next
);

   logic             pending_q, pending_d;
   logic [UW-1:0]    unit_q, unit_d;
   logic [DEPTH-1:0] row_q, row_d;
   logic [DEPTH-1:0] row_shift;

   always_comb begin
      row_shift = stall ? row_q : (row_q >> 1);
      pending_d = (row_shift != '0);
      unit_d    = pending_d ? unit_q : '0;
      row_d     = row_shift;
      // Flush beats a write, and a write beats a same-edge expiry.
      if (flush) begin
         pending_d = 1'b0;
         unit_d    = '0;
         row_d     = '0;
      end else if (wr_en) begin
         pending_d = 1'b1;
         unit_d    = wr_unit;
         row_d     = wr_row;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= 1'b0;
         unit_q    <= '0;
         row_q     <= '0;
      end else begin
         pending_q <= pending_d;
         unit_q    <= unit_d;
         row_q     <= row_d;
      end
   end

   assign pending      = pending_q;
   assign unit         = unit_q;
   assign row          = row_q;
   assign pending_next = pending_d;

endmodule

// File: rtl/multi_port_scoreboard.sv
// Register scoreboard with NRD combinational read ports, one write port,
// WAW hazard detection and a registered count of pending registers.
module multi_port_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF,
   parameter int NUNIT = NUNIT_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter logic [NUNIT*LAT_W-1:0] UNIT_LAT = UNIT_LAT_DEF,
   localparam int AW = $clog2(NREGS),
   localparam int UW = unit_width(NUNIT),
   localparam int CW = $clog2(NREGS+1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD-1:0]       rd_pending,
   output logic [NRD*UW-1:0]    rd_unit,
   output logic [NRD*DEPTH-1:0] rd_row,
   input  logic [AW-1:0]        writeaddr,
   input  logic [UW-1:0]        registerunit,
   input  logic                 enablewrite,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 waw_hazard,
   output logic [CW-1:0]        pending_count
);

   // Slots past NREGS exist only so every address decodes to a defined idle value.
   localparam int NSLOT = 1 << AW;

   logic [NSLOT-1:0] ent_pending;
   logic [NSLOT-1:0] ent_pending_nx;
   logic [UW-1:0]    ent_unit [NSLOT];
   logic [DEPTH-1:0] ent_row  [NSLOT];

   logic [31:0]      unit_ext;
   logic [LAT_W-1:0] lat;
   logic [DEPTH-1:0] new_row;
   logic             wr_valid;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      unit_ext = 32'(registerunit);
      lat      = UNIT_LAT[LAT_W-1:0];
      if (unit_ext < NUNIT) lat = UNIT_LAT[unit_ext*LAT_W +: LAT_W];
      new_row    = DEPTH'(1) << (lat - LAT_W'(1));
      wr_valid   = enablewrite && (writeaddr != '0);
      waw_hazard = wr_valid && ent_pending[writeaddr] && (ent_row[writeaddr] >= new_row);
   end

   for (genvar i = 0; i < NSLOT; i++) begin : g_entry
      if (i == 0 || i >= NREGS) begin : g_idle
         assign ent_pending[i]    = 1'b0;
         assign ent_pending_nx[i] = 1'b0;
         assign ent_unit[i]       = '0;
         assign ent_row[i]        = '0;
      end else begin : g_live
         scoreboard_entry #(.UW(UW), .DEPTH(DEPTH)) u_entry (
            .clock        (clock),
            .reset        (reset),
            .stall        (stall),
            .flush        (flush),
            .wr_en        (wr_valid && (writeaddr == AW'(i))),
            .wr_unit      (registerunit),
            .wr_row       (new_row),
            .pending      (ent_pending[i]),
            .unit         (ent_unit[i]),
            .row          (ent_row[i]),
            .pending_next (ent_pending_nx[i])
         );
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      assign rd_pending[k]             = ent_pending[rd_addr[k*AW +: AW]];
      assign rd_unit[k*UW +: UW]       = ent_unit[rd_addr[k*AW +: AW]];
      assign rd_row[k*DEPTH +: DEPTH]  = ent_row[rd_addr[k*AW +: AW]];
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NSLOT; i++) count_d = count_d + CW'(ent_pending_nx[i]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign pending_count = count_q;

endmodule

// File: tb/tb_multi_port_scoreboard.sv
// Directed bench for multi_port_scoreboard with hand-computed expectations.
module tb_multi_port_scoreboard;

   localparam int AW = 5;
   localparam int UW = 2;
   localparam int DP = 5;
   localparam int NRD = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD-1:0]    rd_pending;
   logic [NRD*UW-1:0] rd_unit;
   logic [NRD*DP-1:0] rd_row;
   logic [AW-1:0]     writeaddr;
   logic [UW-1:0]     registerunit;
   logic              enablewrite;
   logic              stall;
   logic              flush;
   logic              waw_hazard;
   logic [5:0]        pending_count;

   int passed = 0;
   int total  = 0;

   multi_port_scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .rd_addr       (rd_addr),
      .rd_pending    (rd_pending),
      .rd_unit       (rd_unit),
      .rd_row        (rd_row),
      .writeaddr     (writeaddr),
      .registerunit  (registerunit),
      .enablewrite   (enablewrite),
      .stall         (stall),
      .flush         (flush),
      .waw_hazard    (waw_hazard),
      .pending_count (pending_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_p0(input string tag, input logic p, input logic [1:0] u, input logic [4:0] r);
      chk({tag, "_pend"}, 32'(rd_pending[0]), 32'(p));
      chk({tag, "_unit"}, 32'(rd_unit[1:0]), 32'(u));
      chk({tag, "_row"},  32'(rd_row[4:0]),  32'(r));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_port(input int k, input logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [UW-1:0] u);
      writeaddr    = a;
      registerunit = u;
      enablewrite  = 1'b1;
   endtask

   task automatic idle();
      enablewrite = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rd_addr = '0; writeaddr = '0; registerunit = '0;
      enablewrite = 1'b0; stall = 1'b0; flush = 1'b0;
      #1;
      chk("rst_count", 32'(pending_count), 0);
      chk("rst_pend",  32'(rd_pending), 0);
      chk("rst_row",   32'(rd_row), 0);
      #12 reset = 1'b1;

      // r5 through unit0: full five-stage walk then expiry.
      set_port(0, 5); wr(5, 0); #1;
      chk("r5_waw", 32'(waw_hazard), 0);
      step(); idle();
      chk_p0("r5_c0", 1, 0, 5'b10000);
      chk("r5_cnt1", 32'(pending_count), 1);
      step(); chk_p0("r5_c1", 1, 0, 5'b01000);
      step(); chk_p0("r5_c2", 1, 0, 5'b00100);
      step(); chk_p0("r5_c3", 1, 0, 5'b00010);
      step(); chk_p0("r5_c4", 1, 0, 5'b00001);
      chk("r5_cnt_last", 32'(pending_count), 1);
      step(); chk_p0("r5_exp", 0, 0, 5'b00000);
      chk("r5_cnt0", 32'(pending_count), 0);

      // r7 through unit1 with two stalled edges.
      set_port(0, 7); wr(7, 1); step(); idle(); stall = 1'b1;
      chk_p0("r7_w", 1, 1, 5'b00100);
      step(); chk_p0("r7_s1", 1, 1, 5'b00100);
      step(); chk_p0("r7_s2", 1, 1, 5'b00100);
      stall = 1'b0;
      step(); chk_p0("r7_u1", 1, 1, 5'b00010);
      step(); chk_p0("r7_u2", 1, 1, 5'b00001);
      step(); chk_p0("r7_exp", 0, 0, 5'b00000);

      // r3 WAW: later short-latency write over an older long one.
      set_port(0, 3); wr(3, 0); step(); idle();
      step(); chk_p0("r3_pre", 1, 0, 5'b01000);
      wr(3, 3); #1;
      chk("r3_waw1", 32'(waw_hazard), 1);
      step(); idle();
      chk_p0("r3_ovr", 1, 3, 5'b00001);
      wr(3, 0); #1;
      chk("r3_waw0", 32'(waw_hazard), 0);
      step(); idle();
      chk_p0("r3_ovr2", 1, 0, 5'b10000);

      // Writes to r0 are ignored.
      set_port(1, 0); wr(0, 1); #1;
      chk("r0_waw", 32'(waw_hazard), 0);
      step(); idle();
      chk("r0_pend", 32'(rd_pending[1]), 0);
      chk("r0_row",  32'(rd_row[9:5]), 0);
      chk("r0_unit", 32'(rd_unit[3:2]), 0);
      chk("r0_cnt",  32'(pending_count), 1);

      // r9: write coincides with expiry; write wins.
      set_port(0, 9); wr(9, 3); step();
      chk_p0("r9_w", 1, 3, 5'b00001);
      wr(9, 2); #1;
      chk("r9_waw", 32'(waw_hazard), 0);
      step(); idle();
      chk_p0("r9_win", 1, 2, 5'b00010);
      chk("r9_cnt", 32'(pending_count), 2);

      // Fill r1, r2, r4 then flush with a concurrent write to r6.
      wr(1, 0); step(); chk("fill_cnt1", 32'(pending_count), 3);
      wr(2, 0); step(); chk("fill_cnt2", 32'(pending_count), 2);
      wr(4, 0); step(); chk("fill_cnt3", 32'(pending_count), 3);
      set_port(0, 6); set_port(1, 1); wr(6, 0); flush = 1'b1;
      step(); idle(); flush = 1'b0;
      chk("fl_cnt", 32'(pending_count), 0);
      chk_p0("fl_r6", 0, 0, 5'b00000);
      chk("fl_r1_pend", 32'(rd_pending[1]), 0);
      chk("fl_r1_row",  32'(rd_row[9:5]), 0);

      // Reset mid-stream clears asynchronously.
      set_port(0, 5); wr(5, 0); step(); idle();
      chk("mr_cnt_pre", 32'(pending_count), 1);
      reset = 1'b0; #1;
      chk("mr_cnt", 32'(pending_count), 0);
      chk("mr_pend", 32'(rd_pending), 0);
      chk("mr_row", 32'(rd_row[4:0]), 0);
      #2 reset = 1'b1;
      step();
      chk("mr_idle_cnt", 32'(pending_count), 0);
      chk_p0("mr_idle_r5", 0, 0, 5'b00000);
      set_port(0, 8); wr(8, 1); step(); idle();
      chk_p0("mr_r8", 1, 1, 5'b00100);
      chk("mr_r8_cnt", 32'(pending_count), 1);

      // Write lands while stalled; r8 holds.
      set_port(1, 10); stall = 1'b1; wr(10, 2); step(); idle(); stall = 1'b0;
      chk_p0("st_r8", 1, 1, 5'b00100);
      chk("st_r10_pend", 32'(rd_pending[1]), 1);
      chk("st_r10_row",  32'(rd_row[9:5]), 32'(5'b00010));
      chk("st_cnt", 32'(pending_count), 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multi_port_scoreboard.md
MULTI_PORT_SCOREBOARD -- requirements
Module: multi_port_scoreboard

Interface
REQ-001 Parameter NREGS, default 32: tracked architectural registers; AW = $clog2(NREGS).
REQ-002 Parameter NRD, default 4: asynchronous read ports.
REQ-003 Parameter NUNIT, default 4: functional units; UW = max(1, $clog2(NUNIT)).
REQ-004 Parameter DEPTH, default 5: row-vector width, i.e. the maximum tracked latency in cycles.
REQ-005 Parameter UNIT_LAT, packed NUNIT x 3 bits, default unit0=5, unit1=3, unit2=2, unit3=1: per-unit latency, each value in 1..DEPTH.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-009 rd_pending  out  NRD  pending bit per port.
REQ-010 rd_unit  out  NRD*UW  unit per port.
REQ-011 rd_row  out  NRD*DEPTH  row vector per port.
REQ-012 writeaddr  in  AW  register to mark pending.
REQ-013 registerunit  in  UW  producing unit.
REQ-014 enablewrite  in  1  write qualifier.
REQ-015 stall  in  1  freezes row advance.
REQ-016 flush  in  1  synchronous clear of all entries.
REQ-017 waw_hazard  out  1  combinational WAW indication for the current write.
REQ-018 pending_count  out  $clog2(NREGS+1)  registered count of pending entries.

Function
REQ-019 Each entry SHALL hold pending (1 bit), unit (UW bits) and row (DEPTH bits); its invariant is pending == (row != 0).
REQ-020 Read ports SHALL be purely combinational from current state, with no same-cycle write bypass.
REQ-021 An idle entry SHALL read unit=0 and row=0; no X or Z values are permitted.
REQ-022 Each clock with stall=0, every row SHALL shift right by 1; an entry whose row becomes 0 SHALL clear pending and unit in the same edge.
REQ-023 With stall=1, rows SHALL hold their value.
REQ-024 When enablewrite=1 and writeaddr != 0, the entry SHALL be set after the shift step to pending=1, unit=registerunit, row = 1 << (UNIT_LAT[registerunit]-1).
REQ-025 The write SHALL take effect regardless of stall.
REQ-026 On simultaneous expiry and write to the same entry, the write SHALL win.
REQ-027 Register 0 SHALL never become pending; writes addressed to it SHALL be ignored.
REQ-028 registerunit >= NUNIT SHALL be treated as unit 0's latency.
REQ-029 waw_hazard SHALL equal enablewrite & writeaddr!=0 & target pending & (current target row >= new row value); the write still proceeds and overwrites the entry.
REQ-030 flush=1 SHALL clear all entries at the edge and override both shift and write.
REQ-031 pending_count SHALL equal the number of pending entries in the post-edge state; it is updated on the same edge as the entries and never exceeds NREGS-1.

Reset
REQ-032 While reset=0, all entries SHALL be pending=0, unit=0, row=0, and pending_count SHALL be 0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries; the first post-release edge SHALL behave as from the idle state.

Structure
REQ-034 Shared package scoreboard_pkg SHALL hold the entry field widths, the default UNIT_LAT, and the unit encoding constants.
REQ-035 One sub-module, scoreboard_entry, SHALL implement a single entry's shift/expire/write/flush logic and be instantiated NREGS-1 times; register 0 SHALL be tied idle.
REQ-036 pending_count SHALL be a population count computed from the next-state pending bits and then registered.

Verification
REQ-037 Write r5 unit0, no stall -> rd_row for r5 reads 10000, 01000, 00100, 00010, 00001 on successive cycles, then pending=0, unit=0; pending_count goes 1 -> 0.
REQ-038 Write r7 unit1, stall held high for 2 cycles after the write -> r7 row stays 00100 for those 2 cycles, then expires 3 unstalled cycles later.
REQ-039 r3 pending unit0 with row 01000, then write r3 unit3 -> waw_hazard=1; next-cycle row = 00001, unit=3.
REQ-040 Write r0 -> r0 stays idle, pending_count unchanged, waw_hazard=0.
REQ-041 r9 row at 00001 while writing r9 unit2 the same cycle -> r9 row 00010, pending=1.
REQ-042 Pending r1, r2, r4 with flush=1 and a concurrent write to r6 -> all entries idle and pending_count=0; reset pulsed low mid-stream -> outputs zero immediately.
